// File: rtl/ap_ctrl_txn_monitor.sv
// Multi-channel ap_ctrl_hs transaction monitor: per-channel timestamp FIFO, latency and
// stall statistics, sticky protocol errors, and a registered select/read port.
module ap_ctrl_txn_monitor #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 32,
    parameter int TXN_DEPTH = 4,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic [N_CH-1:0]   ap_start,
    input  logic [N_CH-1:0]   ap_ready,
    input  logic [N_CH-1:0]   ap_done,
    input  logic [N_CH-1:0]   ap_continue,
    input  logic [N_CH-1:0]   clr,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   err,
    output logic              frozen
);

    localparam int PTR_W = $clog2(TXN_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int RD_N  = 2 ** CH_W;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TXN_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2,
        ST_ERR    = 2'd3
    } ch_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] ts_q;
    logic             frozen_q;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_val [RD_N];

    // Timestamp keeps counting through the finish cycle, then stops for good.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ts_q     <= '0;
            frozen_q <= 1'b0;
        end else begin
            if (!frozen_q) ts_q <= ts_q + CNT_W'(1);
            if (finish) frozen_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] fifo_q [TXN_DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [OCC_W-1:0] occ_q, occ_d;
        logic [CNT_W-1:0] txn_q, txn_d, last_q, last_d, min_q, min_d;
        logic [CNT_W-1:0] max_q, max_d, stall_q, stall_d;
        logic             ovf_q, ovf_d, unf_q, unf_d;
        ch_state_e        state_q;
        logic             start_ev, done_ev, push, pop, upd;
        logic [CNT_W-1:0] lat;
        logic [CNT_W-1:0] ch_val;

        always_comb begin
            start_ev = ap_start[g] & ap_ready[g];
            done_ev  = ap_done[g] & ap_continue[g];
            push     = 1'b0;
            pop      = 1'b0;
            upd      = 1'b0;
            lat      = '0;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            txn_d    = txn_q;
            last_d   = last_q;
            min_d    = min_q;
            max_d    = max_q;
            stall_d  = stall_q;
            ovf_d    = ovf_q;
            unf_d    = unf_q;

            // Same-cycle start+done: bypass when empty, otherwise swap head for new entry.
            if (start_ev && done_ev) begin
                upd = 1'b1;
                if (occ_q != '0) begin
                    push = 1'b1;
                    pop  = 1'b1;
                    lat  = ts_q - fifo_q[rd_ptr_q];
                end
            end else if (start_ev) begin
                if (occ_q == OCC_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    occ_d = occ_q + OCC_ONE;
                end
            end else if (done_ev) begin
                if (occ_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    pop   = 1'b1;
                    upd   = 1'b1;
                    lat   = ts_q - fifo_q[rd_ptr_q];
                    occ_d = occ_q - OCC_ONE;
                end
            end

            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (upd) begin
                txn_d  = sat_inc(txn_q);
                last_d = lat;
                if (lat < min_q) min_d = lat;
                if (lat > max_q) max_d = lat;
            end
            if (ap_done[g] && !ap_continue[g]) stall_d = sat_inc(stall_q);
        end

        always_ff @(posedge clock) begin
            if (!reset || (clr[g] && !frozen_q)) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                txn_q    <= '0;
                last_q   <= '0;
                min_q    <= '1;
                max_q    <= '0;
                stall_q  <= '0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
                state_q  <= ST_IDLE;
            end else if (!frozen_q) begin
                if (push) fifo_q[wr_ptr_q] <= ts_q;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
                txn_q    <= txn_d;
                last_q   <= last_d;
                min_q    <= min_d;
                max_q    <= max_d;
                stall_q  <= stall_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                if (ovf_d || unf_d)        state_q <= ST_ERR;
                else if (occ_d == '0)      state_q <= ST_IDLE;
                else if (occ_d == OCC_FULL) state_q <= ST_FULL;
                else                       state_q <= ST_ACTIVE;
            end
        end

        always_comb begin
            ch_val = '0;
            case (rd_sel)
                3'd0: ch_val = txn_q;
                3'd1: ch_val = last_q;
                3'd2: ch_val = min_q;
                3'd3: ch_val = max_q;
                3'd4: ch_val = stall_q;
                3'd5: ch_val = CNT_W'(occ_q);
                3'd6: ch_val = {{(CNT_W-2){1'b0}}, unf_q, ovf_q};
                default: ch_val = ts_q;
            endcase
        end

        assign rd_val[g] = ch_val;
        assign busy[g]   = (state_q == ST_ACTIVE) || (state_q == ST_FULL);
        assign err[g]    = ovf_q | unf_q;
    end

    // Select codes beyond the last channel read back as zero.
    for (genvar u = N_CH; u < RD_N; u++) begin : g_pad
        assign rd_val[u] = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_val[rd_ch];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_ap_ctrl_txn_monitor.sv
// Directed bench for ap_ctrl_txn_monitor with hand-computed expected statistics.
module tb_ap_ctrl_txn_monitor;

    localparam int N_CH      = 5;
    localparam int CNT_W     = 32;
    localparam int TXN_DEPTH = 4;
    localparam int CH_W      = 3;
    localparam logic [63:0] ONES = 64'h0000_0000_FFFF_FFFF;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              finish = 1'b0;
    logic [N_CH-1:0]   ap_start = '0;
    logic [N_CH-1:0]   ap_ready = '0;
    logic [N_CH-1:0]   ap_done = '0;
    logic [N_CH-1:0]   ap_continue = '0;
    logic [N_CH-1:0]   clr = '0;
    logic              rd_en = 1'b0;
    logic [CH_W-1:0]   rd_ch = '0;
    logic [2:0]        rd_sel = '0;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   err;
    logic              frozen;

    int n_vec  = 0;
    int n_miss = 0;
    int ts     = 0;
    bit frz_m  = 1'b0;

    ap_ctrl_txn_monitor #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TXN_DEPTH(TXN_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .clr(clr),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .err(err), .frozen(frozen)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (!frz_m) ts++;
    endtask

    task automatic go_to(input int t);
        int guard = 0;
        while (ts < t && guard < 2000) begin
            tick();
            guard++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        ts    = 0;
        frz_m = 1'b0;
    endtask

    task automatic drive(input int ch, input bit st, input bit dn, input bit cont);
        ap_start[ch]    = st;
        ap_ready[ch]    = st;
        ap_done[ch]     = dn;
        ap_continue[ch] = cont;
    endtask

    task automatic idle_all();
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0; clr = '0;
    endtask

    task automatic rd(input int ch, input int sel, input string tag, input logic [63:0] exp);
        rd_en  = 1'b1;
        rd_ch  = ch[CH_W-1:0];
        rd_sel = sel[2:0];
        tick();
        rd_en  = 1'b0;
        chk({tag, "_vld"}, rd_valid, 1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_frozen", frozen, 0);
        reset = 1'b1;
        ts    = 0;
        rd(0, 2, "rst_min", ONES);
        rd(0, 3, "rst_max", 0);
        rd(0, 0, "rst_cnt", 0);

        // Ch0 single transaction, start ts=10, done ts=25
        do_reset();
        go_to(10);
        drive(0, 1, 0, 0);
        tick();
        idle_all();
        chk("c0_busy_11", busy[0], 1);
        go_to(25);
        chk("c0_busy_25", busy[0], 1);
        drive(0, 0, 1, 1);
        tick();
        idle_all();
        chk("c0_busy_26", busy[0], 0);
        rd(0, 1, "c0_last", 15);
        chk("c0_vld_drop", rd_valid, 1);
        tick();
        chk("c0_vld_low", rd_valid, 0);
        rd(0, 2, "c0_min", 15);
        rd(0, 3, "c0_max", 15);
        rd(0, 0, "c0_cnt", 1);
        rd(0, 5, "c0_occ", 0);
        rd(0, 7, "c0_ts", 32);

        // Ch1 three overlapping transactions
        do_reset();
        go_to(5);
        drive(1, 1, 0, 0);
        tick(); tick(); tick();
        idle_all();
        rd(1, 5, "c1_occ3", 3);
        chk("c1_busy", busy[1], 1);
        go_to(20);
        drive(1, 0, 1, 1); tick(); idle_all();
        go_to(30);
        drive(1, 0, 1, 1); tick(); idle_all();
        go_to(40);
        drive(1, 0, 1, 1); tick(); idle_all();
        rd(1, 1, "c1_last", 33);
        rd(1, 2, "c1_min", 15);
        rd(1, 3, "c1_max", 33);
        rd(1, 0, "c1_cnt", 3);
        rd(1, 5, "c1_occ0", 0);
        chk("c1_idle", busy[1], 0);

        // Ch2 overflow, then swap while full
        do_reset();
        drive(2, 1, 0, 0);
        repeat (5) tick();
        idle_all();
        chk("c2_err", err[2], 1);
        rd(2, 6, "c2_errbits", 1);
        rd(2, 5, "c2_occ", 4);
        drive(2, 1, 1, 1);
        tick();
        idle_all();
        rd(2, 5, "c2_occ_swap", 4);
        rd(2, 6, "c2_errbits2", 1);
        rd(2, 0, "c2_cnt", 1);
        rd(2, 1, "c2_last", 7);

        // Reset mid-operation clears the sticky error
        do_reset();
        chk("mid_rst_err", err, 0);
        rd(2, 5, "mid_rst_occ", 0);

        // Ch3 stall, underflow, clear
        drive(3, 1, 0, 0);
        tick();
        drive(3, 0, 1, 0);
        repeat (6) tick();
        drive(3, 0, 1, 1);
        tick();
        idle_all();
        rd(3, 4, "c3_stall", 6);
        rd(3, 0, "c3_cnt", 1);
        rd(3, 1, "c3_last", 7);
        drive(3, 0, 1, 1);
        tick();
        idle_all();
        chk("c3_err", err[3], 1);
        rd(3, 6, "c3_errbits", 2);
        rd(3, 0, "c3_cnt_unf", 1);
        clr[3] = 1'b1;
        drive(3, 1, 0, 0);
        tick();
        idle_all();
        chk("c3_err_clr", err[3], 0);
        chk("c3_busy_clr", busy[3], 0);
        rd(3, 0, "c3_cnt_clr", 0);
        rd(3, 2, "c3_min_clr", ONES);
        rd(3, 5, "c3_occ_clr", 0);
        rd(3, 4, "c3_stall_clr", 0);
        rd(3, 6, "c3_errbits_clr", 0);

        // Ch0 bypass on empty FIFO
        do_reset();
        go_to(3);
        drive(0, 1, 1, 1);
        tick();
        idle_all();
        chk("byp_busy", busy[0], 0);
        rd(0, 1, "byp_last", 0);
        rd(0, 2, "byp_min", 0);
        rd(0, 3, "byp_max", 0);
        rd(0, 0, "byp_cnt", 1);
        rd(0, 5, "byp_occ", 0);

        // Finish freezes statistics and timestamp
        do_reset();
        go_to(2);
        drive(1, 1, 0, 0); tick(); idle_all();
        go_to(9);
        drive(1, 0, 1, 1); tick(); idle_all();
        go_to(100);
        finish = 1'b1;
        drive(0, 1, 0, 0);
        tick();
        frz_m  = 1'b1;
        finish = 1'b0;
        idle_all();
        chk("fin_frozen", frozen, 1);
        drive(1, 1, 1, 1);
        drive(0, 0, 1, 1);
        drive(2, 1, 0, 0);
        clr[1] = 1'b1;
        repeat (3) tick();
        idle_all();
        rd(0, 7, "fin_ts", 101);
        rd(1, 0, "fin_c1_cnt", 1);
        rd(1, 1, "fin_c1_last", 7);
        rd(0, 5, "fin_c0_occ", 1);
        rd(2, 5, "fin_c2_occ", 0);
        rd(N_CH, 0, "fin_bad_ch", 0);
        repeat (4) tick();
        rd(0, 7, "fin_ts_again", 101);
        chk("fin_frozen2", frozen, 1);

        // Reset releases the freeze and restarts the timestamp
        do_reset();
        chk("unfreeze", frozen, 0);
        go_to(5);
        rd(0, 7, "ts_restart", 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
